// File: rtl/fft_smpl_ctrl_if.sv
// Sample-scheduler bus: ADC reader handshake on one side, FFT frame handshake and read port on the other.
// master = fft_smpl_ctrl, slave = the reader/FFT side (or a testbench driving them).
interface fft_smpl_ctrl_if #(
    parameter int LOG2N = 8
);
    logic             oADC_EN;
    logic [15:0]      iADC_DATA;
    logic             iADC_RDY;
    logic             oFRAME_RDY;
    logic             oFRAME_BANK;
    logic             iFRAME_ACK;
    logic [LOG2N-1:0] iRD_ADDR;
    logic [15:0]      oRD_DATA;

    modport master (
        output oADC_EN, oFRAME_RDY, oFRAME_BANK, oRD_DATA,
        input  iADC_DATA, iADC_RDY, iFRAME_ACK, iRD_ADDR
    );

    modport slave (
        input  oADC_EN, oFRAME_RDY, oFRAME_BANK, oRD_DATA,
        output iADC_DATA, iADC_RDY, iFRAME_ACK, iRD_ADDR
    );
endinterface

// File: rtl/fft_smpl_ctrl.sv
// Periodic ADC sample scheduler filling a ping-pong frame buffer for the FFT core.
// Optional macro FFT_SMPL_SIGNED_EN stores samples as two's complement (MSB inverted).
module fft_smpl_ctrl #(
    parameter int LOG2N   = 8,
    parameter int DIV     = 1024,
    parameter int TIMEOUT = 2048
) (
    input  logic                  iCLK,
    input  logic                  iRESET,
    input  logic                  iRUN,
    input  logic                  iCLR_ERR,
    output logic                  oOVERRUN,
    output logic                  oTIMEOUT,
    fft_smpl_ctrl_if.master       bus
);
    localparam int N    = 1 << LOG2N;
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, WAIT_TICK, CONVERT, STORE} state_t;

    state_t           state, state_nxt;
    logic [DIV_W-1:0] div_cnt;
    logic [TO_W-1:0]  to_cnt;
    logic [LOG2N-1:0] wr_addr;
    logic             wr_bank, rd_bank;
    logic [1:0]       full, full_nxt;
    logic [15:0]      smpl;
    logic [15:0]      rd_data_p1;
    logic             adc_en;
    logic [15:0]      mem [2*N];

    logic             tick, fire, to_hit, st_drop, st_write, frame_done, ack_ok, ovr_set;
    logic [15:0]      wr_data;

    function automatic logic [15:0] to_stored(input logic [15:0] code);
`ifdef FFT_SMPL_SIGNED_EN
        return {~code[15], code[14:0]};
`else
        return code;
`endif
    endfunction

    assign tick       = (state != IDLE) && (div_cnt == DIV_W'(DIV - 1));
    assign frame_done = st_write && (&wr_addr);
    assign ack_ok     = bus.iFRAME_ACK && full[rd_bank];
    assign ovr_set    = st_drop || (tick && (state == CONVERT || state == STORE));
    assign wr_data    = to_stored(smpl);

    always_comb begin
        state_nxt = state;
        fire      = 1'b0;
        to_hit    = 1'b0;
        st_drop   = 1'b0;
        st_write  = 1'b0;
        case (state)
            IDLE:      if (iRUN) state_nxt = WAIT_TICK;
            WAIT_TICK: begin
                if (!iRUN) begin
                    state_nxt = IDLE;
                end else if (tick) begin
                    fire      = 1'b1;
                    state_nxt = CONVERT;
                end
            end
            // A conversion is always allowed to finish, even if iRUN has dropped.
            CONVERT: begin
                if (bus.iADC_RDY) begin
                    state_nxt = STORE;
                end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
                    to_hit    = 1'b1;
                    state_nxt = WAIT_TICK;
                end
            end
            STORE: begin
                if (wr_addr == '0 && full[wr_bank]) st_drop  = 1'b1;
                else                                st_write = 1'b1;
                state_nxt = iRUN ? WAIT_TICK : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Set and clear of full[] always hit different banks, so both apply.
    always_comb begin
        full_nxt = full;
        if (frame_done) full_nxt[wr_bank] = 1'b1;
        if (ack_ok)     full_nxt[rd_bank] = 1'b0;
    end

    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            state    <= IDLE;
            div_cnt  <= '0;
            to_cnt   <= '0;
            wr_addr  <= '0;
            wr_bank  <= 1'b0;
            rd_bank  <= 1'b0;
            full     <= 2'b00;
            adc_en   <= 1'b0;
            oOVERRUN <= 1'b0;
            oTIMEOUT <= 1'b0;
        end else begin
            state   <= state_nxt;
            adc_en  <= fire;
            full    <= full_nxt;
            wr_bank <= wr_bank ^ frame_done;
            rd_bank <= rd_bank ^ ack_ok;

            if (state == IDLE || tick) div_cnt <= '0;
            else                       div_cnt <= div_cnt + 1'b1;

            if (fire)                  to_cnt <= '0;
            else if (state == CONVERT) to_cnt <= to_cnt + 1'b1;

            if (state == IDLE) wr_addr <= '0;
            else if (st_write) wr_addr <= wr_addr + 1'b1;

            if (ovr_set)       oOVERRUN <= 1'b1;
            else if (iCLR_ERR) oOVERRUN <= 1'b0;

            if (to_hit)        oTIMEOUT <= 1'b1;
            else if (iCLR_ERR) oTIMEOUT <= 1'b0;
        end
    end

    always_ff @(posedge iCLK) begin
        if (state == CONVERT && bus.iADC_RDY) smpl <= bus.iADC_DATA;
        if (st_write) mem[{wr_bank, wr_addr}] <= wr_data;
    end

    // Read port: one-cycle latency from iRD_ADDR.
    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) rd_data_p1 <= '0;
        else        rd_data_p1 <= mem[{rd_bank, bus.iRD_ADDR}];
    end

    assign bus.oADC_EN     = adc_en;
    assign bus.oFRAME_RDY  = full[rd_bank];
    assign bus.oFRAME_BANK = rd_bank;
    assign bus.oRD_DATA    = rd_data_p1;
endmodule

// File: tb/tb_fft_smpl_ctrl.sv
// Directed testbench for fft_smpl_ctrl with a behavioural ADS8320 reader model.
module tb_fft_smpl_ctrl;
    localparam int LOG2N   = 2;
    localparam int DIV     = 32;
    localparam int TIMEOUT = 64;

    logic iCLK = 1'b0;
    logic iRESET, iRUN, iCLR_ERR;
    logic oOVERRUN, oTIMEOUT;

    fft_smpl_ctrl_if #(.LOG2N(LOG2N)) bus ();

    fft_smpl_ctrl #(.LOG2N(LOG2N), .DIV(DIV), .TIMEOUT(TIMEOUT)) dut (
        .iCLK     (iCLK),
        .iRESET   (iRESET),
        .iRUN     (iRUN),
        .iCLR_ERR (iCLR_ERR),
        .oOVERRUN (oOVERRUN),
        .oTIMEOUT (oTIMEOUT),
        .bus      (bus)
    );

    always #5 iCLK = ~iCLK;

    int cyc = 0;
    always @(posedge iCLK) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [15:0] q[$];
    int lat = 20;
    bit model_on = 1'b1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge iCLK);
            #1;
        end
    endtask

    task automatic wait_frame(input int max);
        bit ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            step(1);
            if (bus.oFRAME_RDY) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq("frame_wait", 32'(ok), 32'd1);
    endtask

    task automatic wait_en(input int max, output int t);
        bit ok = 1'b0;
        t = 0;
        for (int i = 0; i < max; i++) begin
            step(1);
            if (bus.oADC_EN) begin
                ok = 1'b1;
                t  = cyc;
                break;
            end
        end
        check_eq("en_wait", 32'(ok), 32'd1);
    endtask

    task automatic wait_q_empty(input int max);
        bit ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            step(1);
            if (q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq("queue_drain", 32'(ok), 32'd1);
    endtask

    task automatic read_chk(input string tag, input int addr, input logic [15:0] exp);
        bus.iRD_ADDR = LOG2N'(addr);
        step(1);
        check_eq(tag, 32'(bus.oRD_DATA), 32'(exp));
    endtask

    task automatic pulse_ack();
        bus.iFRAME_ACK = 1'b1;
        step(1);
        bus.iFRAME_ACK = 1'b0;
    endtask

    task automatic pulse_clr();
        iCLR_ERR = 1'b1;
        step(1);
        iCLR_ERR = 1'b0;
    endtask

    // Reader model: answers lat cycles after each oADC_EN with the next queued code.
    initial begin
        bus.iADC_RDY  = 1'b0;
        bus.iADC_DATA = 16'h0000;
        forever begin
            @(posedge iCLK);
            #1;
            if (bus.oADC_EN && model_on) begin
                repeat (lat) @(posedge iCLK);
                #1;
                if (q.size() > 0) bus.iADC_DATA = q.pop_front();
                else              bus.iADC_DATA = 16'h0000;
                bus.iADC_RDY = 1'b1;
                @(posedge iCLK);
                #1;
                bus.iADC_RDY = 1'b0;
            end
        end
    end

    initial begin
        int t0, t1, t2;
        iRESET         = 1'b1;
        iRUN           = 1'b0;
        iCLR_ERR       = 1'b0;
        bus.iFRAME_ACK = 1'b0;
        bus.iRD_ADDR   = '0;
        step(3);
        check_eq("rst_adc_en",  32'(bus.oADC_EN),     32'd0);
        check_eq("rst_frm_rdy", 32'(bus.oFRAME_RDY),  32'd0);
        check_eq("rst_frm_bank",32'(bus.oFRAME_BANK), 32'd0);
        check_eq("rst_rd_data", 32'(bus.oRD_DATA),    32'd0);
        check_eq("rst_overrun", 32'(oOVERRUN),        32'd0);
        check_eq("rst_timeout", 32'(oTIMEOUT),        32'd0);
        iRESET = 1'b0;
        step(2);

        // Frame of 1..4, then keep running without ACK to force drops.
        for (int v = 1; v <= 16; v++) q.push_back(16'(v));
        iRUN = 1'b1;
        t0 = cyc;
        wait_en(100, t1);
        check_eq("first_en_delay", 32'(t1 - t0), 32'(DIV + 1));
        wait_en(100, t2);
        check_eq("en_period", 32'(t2 - t1), 32'(DIV));
        wait_frame(400);
        check_eq("f0_bank",    32'(bus.oFRAME_BANK), 32'd0);
        check_eq("f0_overrun", 32'(oOVERRUN),        32'd0);
        for (int a = 0; a < 4; a++) read_chk("f0_read", a, 16'(a + 1));

        wait_q_empty(2000);
        step(3);
        iRUN = 1'b0;
        step(5);
        check_eq("drop_overrun", 32'(oOVERRUN),        32'd1);
        check_eq("drop_rdy",     32'(bus.oFRAME_RDY),  32'd1);
        check_eq("drop_bank",    32'(bus.oFRAME_BANK), 32'd0);
        pulse_ack();
        check_eq("ack1_bank", 32'(bus.oFRAME_BANK), 32'd1);
        check_eq("ack1_rdy",  32'(bus.oFRAME_RDY),  32'd1);
        for (int a = 0; a < 4; a++) read_chk("f1_read", a, 16'(a + 5));
        pulse_ack();
        check_eq("ack2_rdy",  32'(bus.oFRAME_RDY),  32'd0);
        check_eq("ack2_bank", 32'(bus.oFRAME_BANK), 32'd0);
        pulse_ack();
        check_eq("ack_ignored_bank", 32'(bus.oFRAME_BANK), 32'd0);
        pulse_clr();
        check_eq("clr_overrun", 32'(oOVERRUN), 32'd0);

        // Reader never answers.
        model_on = 1'b0;
        iRUN = 1'b1;
        wait_en(100, t0);
        begin
            bit seen = 1'b0;
            t1 = 0;
            for (int i = 0; i < 100; i++) begin
                step(1);
                if (oTIMEOUT) begin
                    seen = 1'b1;
                    t1 = cyc;
                    break;
                end
            end
            check_eq("timeout_seen", 32'(seen), 32'd1);
        end
        check_eq("timeout_latency", 32'(t1 - t0), 32'(TIMEOUT));
        wait_en(100, t2);
        check_eq("en_after_timeout", 32'(t2 - t0), 32'(TIMEOUT + DIV));
        pulse_clr();
        check_eq("clr_timeout", 32'(oTIMEOUT), 32'd0);
        iRUN = 1'b0;
        step(100);
        model_on = 1'b1;
        pulse_clr();
        check_eq("clr_all_ovr", 32'(oOVERRUN), 32'd0);
        check_eq("clr_all_to",  32'(oTIMEOUT), 32'd0);

        // Reader slower than the sample period: every second tick is lost.
        lat = 40;
        for (int v = 0; v < 4; v++) q.push_back(16'h0021 + 16'(v));
        iRUN = 1'b1;
        wait_en(100, t1);
        wait_en(200, t2);
        check_eq("slow_en_period", 32'(t2 - t1), 32'(2 * DIV));
        check_eq("slow_overrun",   32'(oOVERRUN), 32'd1);
        wait_frame(600);
        iRUN = 1'b0;
        step(3);
        check_eq("slow_bank", 32'(bus.oFRAME_BANK), 32'd0);
        for (int a = 0; a < 4; a++) read_chk("slow_read", a, 16'h0021 + 16'(a));
        pulse_ack();
        check_eq("slow_ack_rdy", 32'(bus.oFRAME_RDY), 32'd0);
        pulse_clr();

        // Partial frame discarded when iRUN drops.
        lat = 20;
        q.push_back(16'h0031);
        q.push_back(16'h0032);
        iRUN = 1'b1;
        wait_q_empty(300);
        step(3);
        iRUN = 1'b0;
        step(5);
        for (int v = 0; v < 4; v++) q.push_back(16'h0041 + 16'(v));
        iRUN = 1'b1;
        wait_frame(400);
        iRUN = 1'b0;
        step(3);
        check_eq("restart_bank",    32'(bus.oFRAME_BANK), 32'd1);
        check_eq("restart_overrun", 32'(oOVERRUN),        32'd0);
        for (int a = 0; a < 4; a++) read_chk("restart_read", a, 16'h0041 + 16'(a));
        pulse_ack();

        // Sample coding at the extremes of the code range.
        q.push_back(16'h8000);
        q.push_back(16'h0000);
        q.push_back(16'h7FFF);
        q.push_back(16'hFFFF);
        iRUN = 1'b1;
        wait_frame(400);
        iRUN = 1'b0;
        step(3);
        check_eq("code_bank", 32'(bus.oFRAME_BANK), 32'd0);
`ifdef FFT_SMPL_SIGNED_EN
        read_chk("code_read0", 0, 16'h0000);
        read_chk("code_read1", 1, 16'h8000);
        read_chk("code_read2", 2, 16'hFFFF);
        read_chk("code_read3", 3, 16'h7FFF);
`else
        read_chk("code_read0", 0, 16'h8000);
        read_chk("code_read1", 1, 16'h0000);
        read_chk("code_read2", 2, 16'h7FFF);
        read_chk("code_read3", 3, 16'hFFFF);
`endif
        pulse_ack();
        check_eq("final_rdy", 32'(bus.oFRAME_RDY), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
